// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the stall/flush controller.
package hazard_stall_unit_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DEF_CNT_W   = 32;
    localparam int         DEF_TIMEOUT = 255;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard inputs from the pipeline and stall/flush/status outputs back to it.
interface hazard_stall_unit_if #(
    parameter int CNT_W = hazard_stall_unit_pkg::DEF_CNT_W
) ();
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic             UsesRs1D;
    logic             UsesRs2D;
    logic [4:0]       RdE;
    logic             MemReadE;
    logic             BranchTakenE;
    logic             DmemReqM;
    logic             DmemReadyM;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] LoadUseCount;
    logic [CNT_W-1:0] FlushCount;
    logic [CNT_W-1:0] MemStallCount;

    modport master (
        output Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdE, MemReadE, BranchTakenE,
               DmemReqM, DmemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               MemTimeout, LoadUseCount, FlushCount, MemStallCount
    );

    modport slave (
        input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdE, MemReadE, BranchTakenE,
               DmemReqM, DmemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               MemTimeout, LoadUseCount, FlushCount, MemStallCount
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, taken-branch and data-memory-wait hazards,
// with saturating event counters and a sticky memory-timeout flag.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_unit_if.slave  hz
);

    localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_Q  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_timeout;
    logic              w_load_use;
    logic              w_mem_wait;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic              w_flush_d, w_flush_e, w_flush_w;
    logic              w_inc_lu, w_inc_fl, w_inc_ms;
    logic              w_wait_clr;
    logic              w_wait_inc;
    logic [WAIT_W-1:0] w_wait_cnt;

    // Hazard detection and priority: reset > memory wait > branch > load-use.
    always_comb begin
        w_load_use = hz.MemReadE && (hz.RdE != REG_ZERO) &&
                     ((hz.UsesRs1D && (hz.RdE == hz.Rs1D)) ||
                      (hz.UsesRs2D && (hz.RdE == hz.Rs2D)));
        w_mem_wait = hz.DmemReqM && !hz.DmemReadyM;
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_stall_m  = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_flush_w  = 1'b0;
        w_inc_lu   = 1'b0;
        w_inc_fl   = 1'b0;
        w_inc_ms   = 1'b0;
        if (reset) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_mem_wait) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
            w_inc_ms  = 1'b1;
        end else if (hz.BranchTakenE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_inc_fl  = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
            w_inc_lu  = 1'b1;
        end
    end

    assign hz.StallF = w_stall_f;
    assign hz.StallD = w_stall_d;
    assign hz.StallE = w_stall_e;
    assign hz.StallM = w_stall_m;
    assign hz.FlushD = w_flush_d;
    assign hz.FlushE = w_flush_e;
    assign hz.FlushW = w_flush_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A dropped request while waiting is treated like ready.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_mem_wait) w_state_next = MEM_WAIT;
            MEM_WAIT: if (hz.DmemReadyM || !hz.DmemReqM) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Wait counter is zero outside a wait, so its first increment is the "load 1".
    assign w_wait_clr = reset || !w_mem_wait;
    assign w_wait_inc = w_mem_wait && (w_wait_cnt != TIMEOUT_Q);

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (w_wait_clr),
        .inc   (w_wait_inc),
        .q     (w_wait_cnt)
    );

    // Sets on the edge that completes the TIMEOUT-th consecutive wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_mem_wait && (w_wait_cnt >= TIMEOUT_M1)) begin
            r_timeout <= 1'b1;
        end
    end

    assign hz.MemTimeout = r_timeout;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_lu),
        .q     (hz.LoadUseCount)
    );

    sat_counter #(.W(CNT_W)) u_fl_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_fl),
        .q     (hz.FlushCount)
    );

    sat_counter #(.W(CNT_W)) u_ms_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_ms),
        .q     (hz.MemStallCount)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default and narrow/short-timeout)
// on shared stimulus, checked against a counting reference model every cycle.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       UsesRs1D, UsesRs2D, MemReadE, BranchTakenE, DmemReqM, DmemReadyM;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(32)) if_a ();
    hazard_stall_unit_if #(.CNT_W(2))  if_b ();

    assign if_a.Rs1D = Rs1D;          assign if_b.Rs1D = Rs1D;
    assign if_a.Rs2D = Rs2D;          assign if_b.Rs2D = Rs2D;
    assign if_a.UsesRs1D = UsesRs1D;  assign if_b.UsesRs1D = UsesRs1D;
    assign if_a.UsesRs2D = UsesRs2D;  assign if_b.UsesRs2D = UsesRs2D;
    assign if_a.RdE = RdE;            assign if_b.RdE = RdE;
    assign if_a.MemReadE = MemReadE;  assign if_b.MemReadE = MemReadE;
    assign if_a.BranchTakenE = BranchTakenE;  assign if_b.BranchTakenE = BranchTakenE;
    assign if_a.DmemReqM = DmemReqM;          assign if_b.DmemReqM = DmemReqM;
    assign if_a.DmemReadyM = DmemReadyM;      assign if_b.DmemReadyM = DmemReadyM;

    hazard_stall_unit #(.CNT_W(32), .TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .hz(if_a.slave));
    hazard_stall_unit #(.CNT_W(2), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .hz(if_b.slave));

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [6:0] ctl_a, ctl_b;
    assign ctl_a = {if_a.StallF, if_a.StallD, if_a.StallE, if_a.StallM,
                    if_a.FlushD, if_a.FlushE, if_a.FlushW};
    assign ctl_b = {if_b.StallF, if_b.StallD, if_b.StallE, if_b.StallM,
                    if_b.FlushD, if_b.FlushE, if_b.FlushW};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    // Reference model: event counts kept unbounded and clamped only when compared.
    longint lu_n = 0, fl_n = 0, ms_n = 0;
    int     run = 0;
    bit     tout_a = 1'b0, tout_b = 1'b0, st_wait = 1'b0;

    initial begin
        bit         mw, lu, br;
        logic [6:0] exp_ctl;
        forever begin
            @(negedge clk);
            mw = DmemReqM && !DmemReadyM;
            lu = MemReadE && (RdE != 5'd0) &&
                 ((UsesRs1D && RdE == Rs1D) || (UsesRs2D && RdE == Rs2D));
            br = BranchTakenE;
            if (reset)   exp_ctl = 7'b0000111;
            else if (mw) exp_ctl = 7'b1111001;
            else if (br) exp_ctl = 7'b0000110;
            else if (lu) exp_ctl = 7'b1100010;
            else         exp_ctl = 7'b0000000;
            chk("ctl_a", 64'(ctl_a), 64'(exp_ctl));
            chk("ctl_b", 64'(ctl_b), 64'(exp_ctl));
            chk("lu_cnt_a", 64'(if_a.LoadUseCount), sat(lu_n, 32));
            chk("fl_cnt_a", 64'(if_a.FlushCount), sat(fl_n, 32));
            chk("ms_cnt_a", 64'(if_a.MemStallCount), sat(ms_n, 32));
            chk("lu_cnt_b", 64'(if_b.LoadUseCount), sat(lu_n, 2));
            chk("fl_cnt_b", 64'(if_b.FlushCount), sat(fl_n, 2));
            chk("ms_cnt_b", 64'(if_b.MemStallCount), sat(ms_n, 2));
            chk("tout_a", 64'(if_a.MemTimeout), 64'(tout_a));
            chk("tout_b", 64'(if_b.MemTimeout), 64'(tout_b));
            chk("state_a", 64'(dut_a.r_state), 64'(st_wait));
            // Inputs stay put until after the next rising edge, so advance now.
            if (reset) begin
                lu_n = 0; fl_n = 0; ms_n = 0; run = 0;
                tout_a = 1'b0; tout_b = 1'b0; st_wait = 1'b0;
            end else begin
                if (mw) begin
                    ms_n++;
                    run++;
                    if (run >= 255) tout_a = 1'b1;
                    if (run >= 4)   tout_b = 1'b1;
                end else begin
                    run = 0;
                    if (br)      fl_n++;
                    else if (lu) lu_n++;
                end
                st_wait = mw;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        UsesRs1D = 1'b0; UsesRs2D = 1'b0; MemReadE = 1'b0;
        BranchTakenE = 1'b0; DmemReqM = 1'b0; DmemReadyM = 1'b0;
    endtask

    task automatic load_use();
        idle();
        MemReadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; UsesRs1D = 1'b1;
    endtask

    task automatic mem_wait();
        idle();
        DmemReqM = 1'b1; DmemReadyM = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        #2;
        chk("rst_ctl", 64'(ctl_a), 64'(7'b0000111));
        chk("rst_lu_cnt", 64'(if_a.LoadUseCount), 64'd0);
        cyc(); reset = 1'b0; idle(); #2;
        chk("idle_ctl", 64'(ctl_a), 64'd0);
        chk("idle_ms_cnt", 64'(if_a.MemStallCount), 64'd0);

        // Load-use: one bubble, counted on the following edge.
        cyc(); load_use(); #2;
        chk("lu_ctl", 64'(ctl_a), 64'(7'b1100010));
        cyc(); idle(); #2;
        chk("lu_cnt_1", 64'(if_a.LoadUseCount), 64'd1);
        cyc(); load_use(); RdE = 5'd0; Rs1D = 5'd0; #2;
        chk("lu_x0_ctl", 64'(ctl_a), 64'd0);
        cyc(); idle(); #2;
        chk("lu_x0_cnt", 64'(if_a.LoadUseCount), 64'd1);

        // Branch wins over a simultaneous load-use.
        cyc(); idle(); BranchTakenE = 1'b1; MemReadE = 1'b1; RdE = 5'd7;
        Rs2D = 5'd7; UsesRs2D = 1'b1; #2;
        chk("br_lu_ctl", 64'(ctl_a), 64'(7'b0000110));
        cyc(); idle(); #2;
        chk("br_fl_cnt", 64'(if_a.FlushCount), 64'd1);
        chk("br_lu_cnt", 64'(if_a.LoadUseCount), 64'd1);

        // Three-cycle memory wait then ready.
        for (int k = 0; k < 3; k++) begin
            cyc(); mem_wait(); #2;
            chk("mw_ctl", 64'(ctl_a), 64'(7'b1111001));
        end
        cyc(); mem_wait(); DmemReadyM = 1'b1; #2;
        chk("mw_rdy_ctl", 64'(ctl_a), 64'd0);
        chk("mw_ms_cnt", 64'(if_a.MemStallCount), 64'd3);
        cyc(); idle(); #2;
        chk("mw_state", 64'(dut_a.r_state), 64'd0);

        // Six-cycle wait against the TIMEOUT=4 instance.
        for (int k = 1; k <= 6; k++) begin
            cyc(); mem_wait(); #2;
            chk("to_flag_b", 64'(if_b.MemTimeout), 64'(k >= 5));
            chk("to_stall_b", 64'(if_b.StallM), 64'd1);
        end
        cyc(); mem_wait(); DmemReadyM = 1'b1; #2;
        chk("to_rdy_flag_b", 64'(if_b.MemTimeout), 64'd1);
        cyc(); idle(); #2;
        chk("to_sticky_b", 64'(if_b.MemTimeout), 64'd1);
        chk("to_flag_a", 64'(if_a.MemTimeout), 64'd0);

        // Reset in the second wait cycle.
        cyc(); mem_wait();
        cyc(); mem_wait(); reset = 1'b1; #2;
        chk("rst_mid_ctl", 64'(ctl_a), 64'(7'b0000111));
        cyc(); reset = 1'b0; idle(); #2;
        chk("rst_mid_ms", 64'(if_a.MemStallCount), 64'd0);
        chk("rst_mid_fl", 64'(if_a.FlushCount), 64'd0);
        chk("rst_mid_tout_b", 64'(if_b.MemTimeout), 64'd0);
        chk("rst_mid_state", 64'(dut_a.r_state), 64'd0);

        // Saturation of the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            cyc(); load_use();
        end
        cyc(); idle(); #2;
        chk("sat_lu_b", 64'(if_b.LoadUseCount), 64'd3);
        chk("sat_lu_a", 64'(if_a.LoadUseCount), 64'd5);

        // Random traffic; small register range so matches are frequent.
        for (int k = 0; k < 3000; k++) begin
            cyc();
            reset        = ($urandom_range(0, 99) == 0);
            Rs1D         = 5'($urandom_range(0, 3));
            Rs2D         = 5'($urandom_range(0, 3));
            RdE          = 5'($urandom_range(0, 3));
            UsesRs1D     = 1'($urandom_range(0, 1));
            UsesRs2D     = 1'($urandom_range(0, 1));
            MemReadE     = 1'($urandom_range(0, 1));
            BranchTakenE = ($urandom_range(0, 4) == 0);
            DmemReqM     = ($urandom_range(0, 2) != 0);
            DmemReadyM   = ($urandom_range(0, 2) == 0);
        end

        // Long wait reaching the default timeout.
        cyc(); reset = 1'b1; idle();
        cyc(); reset = 1'b0;
        for (int k = 0; k < 260; k++) begin
            cyc(); mem_wait();
        end
        #2;
        chk("long_tout_a", 64'(if_a.MemTimeout), 64'd1);
        chk("long_ms_a", 64'(if_a.MemStallCount), 64'd259);
        cyc(); mem_wait(); DmemReadyM = 1'b1;
        cyc(); idle();
        cyc();
        #2;
        chk("long_sticky_a", 64'(if_a.MemTimeout), 64'd1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage RISC-V pipeline, complementing the EX-stage operand bypass. It covers the hazards that bypassing cannot resolve: load-use dependencies, taken-branch wrong-path fetches, and multi-cycle data-memory waits. It drives the enable and clear controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating performance counters plus a sticky memory-timeout flag.

## Interface
- CNT_W, 32, width of each performance counter
- TIMEOUT, 255, consecutive memory-wait cycles after which MemTimeout sets
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  5 each  source registers of the instruction in ID
- UsesRs1D, UsesRs2D  in  1 each  instruction in ID actually reads that source
- RdE  in  5  destination register of the instruction in EX
- MemReadE  in  1  instruction in EX is a load
- BranchTakenE  in  1  branch/jump resolved taken in EX
- DmemReqM  in  1  instruction in MEM is accessing data memory
- DmemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / IF/ID / ID/EX / EX/MEM register
- FlushD, FlushE, FlushW  out  1 each  clear IF/ID / ID/EX / MEM/WB to a bubble
- MemTimeout  out  1  sticky; a memory wait reached TIMEOUT cycles
- LoadUseCount, FlushCount, MemStallCount  out  CNT_W each  saturating event counters

## Operation
- Load-use condition: MemReadE && RdE!=0 && ((UsesRs1D && RdE==Rs1D) || (UsesRs2D && RdE==Rs2D)). Response: StallF=StallD=1 and FlushE=1, inserting one bubble.
- Branch condition: BranchTakenE. Response: FlushD=FlushE=1 and no stalls.
- Memory-wait condition: DmemReqM && !DmemReadyM. Response: StallF=StallD=StallE=StallM=1 and FlushW=1; every other output is 0.
- Priority, highest first: reset, then memory wait, then branch, then load-use.
  - A branch and a load-use in the same cycle: the branch response only. The dependent instruction is on the wrong path.
  - A branch or load-use during a memory wait is suppressed. It is re-evaluated once the pipeline unfreezes, because the inputs are held.
- FSM states:
  - IDLE: memory-wait condition → MEM_WAIT, wait counter loads 1.
  - MEM_WAIT: DmemReadyM → IDLE. Otherwise the wait counter increments, saturating at TIMEOUT.
  - On the edge where the wait counter equals TIMEOUT while still waiting, MemTimeout sets. It stays set until reset. The stall is not released.
- Counters increment by 1 per cycle in which the corresponding response is actually applied, after priority. All three saturate at 2^CNT_W−1.
  - LoadUseCount: load-use cycles.
  - FlushCount: branch cycles.
  - MemStallCount: memory-wait cycles.
- During reset:
  - All Stall* outputs = 0; FlushD = FlushE = FlushW = 1, draining the pipeline.
  - State = IDLE, wait counter = 0, MemTimeout = 0, all counters = 0.
  - No counter increments in a reset cycle.

## Timing
- Stall and flush outputs are combinational from the current inputs and reset, with zero-cycle latency. Consumers sample them at the next rising clk.
- State, wait counter, MemTimeout and the event counters are registered. They reflect an event one cycle after the cycle in which it occurred.
- Load-use lasts exactly one cycle: after the bubble, RdE no longer holds the load.
- Memory-wait handshake:
  - DmemReqM stays asserted until DmemReadyM, guaranteed by StallM.
  - A ready in the first request cycle causes no stall and no state change.
  - After an N-cycle wait (N≥1 not-ready cycles), MemStallCount rises by N.
- Reset asserted mid-wait: IDLE on the next edge. All outputs follow the reset values in the reset cycle itself.
- MEM_WAIT with DmemReqM deasserted (illegal): treated as ready, return to IDLE.

## Structure
- A shared pipeline package holds:
  - the FSM state encoding (IDLE=0, MEM_WAIT=1);
  - the constant REG_ZERO = 5'd0;
  - default CNT_W and TIMEOUT.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output q). It is instantiated four times: the three event counters, plus the wait counter with its own width.
- Hazard detection and output priority are in a single combinational block in the top module.

## Test plan
- Load-use: MemReadE=1, RdE=5, Rs1D=5, UsesRs1D=1 for one cycle → StallF=StallD=FlushE=1 that cycle; LoadUseCount 0→1 next cycle. With RdE=0 → no stall.
- Branch combined with load-use: BranchTakenE=1 plus the load-use condition in the same cycle → FlushD=FlushE=1, StallF=StallD=0; FlushCount+1, LoadUseCount unchanged.
- Memory wait: DmemReqM=1, DmemReadyM=0 for 3 cycles, then ready → four-way stall plus FlushW for 3 cycles, released in the ready cycle; MemStallCount=3; state back to IDLE.
- Timeout: TIMEOUT=4 and a 6-cycle wait → MemTimeout=1 from the edge after the 4th wait cycle; the stall continues until ready; MemTimeout stays 1 until reset.
- Reset mid-wait: assert reset in the 2nd wait cycle → stalls 0 and flushes 1 that cycle; afterwards counters=0, MemTimeout=0, state IDLE.
- Saturation: CNT_W=2 and 5 consecutive load-use cycles → LoadUseCount stops at 3.
